jogador_automatico: RTL and testbench



---
 rtl/jogador_pkg.sv | 30 +++
 rtl/jogador_memoria_seq.sv | 27 ++
 rtl/jogador_automatico.sv | 221 ++++++++++++++++++++++
 tb/tb_jogador_automatico.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jogador_pkg.sv
// Shared types for the automatic memory-game player.
// Optional feature macro used by the player: JOGADOR_ERRO_PROPOSITAL_EN.
package jogador_pkg;

    // Player states; the numeric value is exported on db_estado.
    typedef enum logic [3:0] {
        INICIAL   = 4'd0,
        DISPARA   = 4'd1,
        OBSERVA   = 4'd2,
        ESPERA    = 4'd3,
        PRESSIONA = 4'd4,
        SOLTA     = 4'd5,
        AGUARDA   = 4'd6,
        FIM       = 4'd7
    } estado_t;

    // Game outcome as reported on resultado.
    typedef enum logic [1:0] {
        RES_NENHUM  = 2'b00,
        RES_GANHOU  = 2'b01,
        RES_PERDEU  = 2'b10,
        RES_TIMEOUT = 2'b11
    } resultado_t;

    // Corrupted press value used to provoke a deliberate loss.
    function automatic logic [3:0] rotaciona_esq(input logic [3:0] v);
        return {v[2:0], v[3]};
    endfunction

endpackage

// File: rtl/jogador_memoria_seq.sv
// Sequence memory for the automatic player: synchronous write, asynchronous read.
// Contents have no reset; every entry is written before it is read back.
module jogador_memoria_seq #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = 4,
    localparam int unsigned AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk_i,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Store one observed item per write strobe.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/jogador_automatico.sv
// Automatic player for jogo_desafio_memoria: starts a game, records each round's LED
// sequence and replays it as timed button presses until the game reports an outcome.
// Optional feature macro: JOGADOR_ERRO_PROPOSITAL_EN (corrupts the last press of
// round ERR_ROUND to force a loss).
module jogador_automatico
    import jogador_pkg::*;
#(
    parameter int unsigned MAX_JOGADAS  = 16,
    parameter int unsigned JOGAR_CYCLES = 5,
    parameter int unsigned PRESS_CYCLES = 10,
    parameter int unsigned GAP_CYCLES   = 10,
    parameter int unsigned ERR_ROUND    = 5
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [3:0] leds,
    input  logic       pronto,
    input  logic       ganhou,
    input  logic       perdeu,
    input  logic       timeout,
    output logic       jogar,
    output logic [3:0] botoes,
    output logic       ocupado,
    output logic [1:0] resultado,
    output logic [4:0] db_rodada,
    output logic [3:0] db_estado
);

    localparam int unsigned IDX_W   = $clog2(MAX_JOGADAS);
    // The observe index must be able to reach MAX_JOGADAS itself to end the last round.
    localparam int unsigned OBS_W   = $clog2(MAX_JOGADAS + 1);
    localparam int unsigned CNT_MAX = (JOGAR_CYCLES > PRESS_CYCLES) ?
                                      ((JOGAR_CYCLES > GAP_CYCLES) ? JOGAR_CYCLES : GAP_CYCLES) :
                                      ((PRESS_CYCLES > GAP_CYCLES) ? PRESS_CYCLES : GAP_CYCLES);
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    estado_t           state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [4:0]        rodada_q, rodada_d;
    logic [OBS_W-1:0]  obs_idx_q, obs_idx_d;
    logic [IDX_W-1:0]  rep_idx_q, rep_idx_d;
    resultado_t        resultado_q, resultado_d;
    logic              jogar_q, jogar_d;
    logic [3:0]        botoes_q, botoes_d;
    logic [3:0]        leds_q;

    logic              mem_we;
    logic [3:0]        mem_rdata;
    logic [3:0]        press_val;
    logic              evento;
    logic              fim_flag;
    logic [4:0]        obs_ext;
    logic [4:0]        rep_ext;
    logic              unused_ok;

    // pronto is informational only.
    assign unused_ok = pronto ^ (ERR_ROUND == 0);

    jogador_memoria_seq #(
        .DEPTH (MAX_JOGADAS),
        .WIDTH (4)
    ) u_memoria (
        .clk_i   (clock),
        .we_i    (mem_we),
        .waddr_i (obs_idx_q[IDX_W-1:0]),
        .wdata_i (leds),
        .raddr_i (rep_idx_d),
        .rdata_o (mem_rdata)
    );

    assign evento   = (leds != 4'd0) && (leds_q == 4'd0);
    assign fim_flag = ganhou | perdeu | timeout;
    assign obs_ext  = 5'(obs_idx_q);
    assign rep_ext  = 5'(rep_idx_q);

    // Value to drive while pressing; optionally corrupted on the last press of ERR_ROUND.
    always_comb begin
        press_val = mem_rdata;
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
        if ((rodada_q == 5'(ERR_ROUND)) && (5'(rep_idx_d) == rodada_q - 5'd1)) begin
            press_val = rotaciona_esq(mem_rdata);
        end
`endif
    end

    // Next-state, counters and registered-output next values.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        rodada_d    = rodada_q;
        obs_idx_d   = obs_idx_q;
        rep_idx_d   = rep_idx_q;
        resultado_d = resultado_q;
        mem_we      = 1'b0;

        unique case (state_q)
            INICIAL, FIM: begin
                if (iniciar) begin
                    resultado_d = RES_NENHUM;
                    cnt_d       = '0;
                    obs_idx_d   = '0;
                    rep_idx_d   = '0;
                    rodada_d    = 5'd1;
                    state_d     = DISPARA;
                end
            end
            DISPARA: begin
                if (cnt_q == CNT_W'(JOGAR_CYCLES - 1)) begin
                    cnt_d     = '0;
                    obs_idx_d = '0;
                    state_d   = OBSERVA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            OBSERVA: begin
                // Only a 0 -> nonzero edge records an item; extra items are dropped.
                if (evento && (obs_ext < rodada_q)) begin
                    mem_we    = 1'b1;
                    obs_idx_d = obs_idx_q + OBS_W'(1);
                end
                if ((obs_ext == rodada_q) && (leds == 4'd0)) begin
                    cnt_d   = '0;
                    state_d = ESPERA;
                end
            end
            ESPERA: begin
                if (cnt_q == CNT_W'(GAP_CYCLES - 1)) begin
                    cnt_d     = '0;
                    rep_idx_d = '0;
                    state_d   = PRESSIONA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            PRESSIONA: begin
                if (cnt_q == CNT_W'(PRESS_CYCLES - 1)) begin
                    cnt_d   = '0;
                    state_d = SOLTA;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            SOLTA: begin
                if (cnt_q == CNT_W'(PRESS_CYCLES - 1)) begin
                    cnt_d = '0;
                    if (rep_ext < rodada_q - 5'd1) begin
                        rep_idx_d = rep_idx_q + IDX_W'(1);
                        state_d   = PRESSIONA;
                    end else if (rodada_q == 5'(MAX_JOGADAS)) begin
                        state_d = AGUARDA;
                    end else begin
                        rodada_d  = rodada_q + 5'd1;
                        obs_idx_d = '0;
                        state_d   = OBSERVA;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            AGUARDA: begin
                state_d = AGUARDA;
            end
            default: begin
                state_d = INICIAL;
            end
        endcase

        // A terminal flag from the game overrides whatever the round was doing.
        if ((state_q != INICIAL) && (state_q != FIM) && fim_flag) begin
            state_d = FIM;
            cnt_d   = '0;
            mem_we  = 1'b0;
            if (ganhou) begin
                resultado_d = RES_GANHOU;
            end else if (timeout) begin
                resultado_d = RES_TIMEOUT;
            end else begin
                resultado_d = RES_PERDEU;
            end
        end

        // Outputs are registered from the next state so they line up with it.
        jogar_d  = (state_d == DISPARA);
        botoes_d = (state_d == PRESSIONA) ? press_val : 4'd0;
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= INICIAL;
            cnt_q       <= '0;
            rodada_q    <= 5'd0;
            obs_idx_q   <= '0;
            rep_idx_q   <= '0;
            resultado_q <= RES_NENHUM;
            jogar_q     <= 1'b0;
            botoes_q    <= 4'd0;
            leds_q      <= 4'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            rodada_q    <= rodada_d;
            obs_idx_q   <= obs_idx_d;
            rep_idx_q   <= rep_idx_d;
            resultado_q <= resultado_d;
            jogar_q     <= jogar_d;
            botoes_q    <= botoes_d;
            leds_q      <= leds;
        end
    end

    assign jogar     = jogar_q;
    assign botoes    = botoes_q;
    assign ocupado   = (state_q != INICIAL) && (state_q != FIM);
    assign resultado = resultado_q;
    assign db_rodada = rodada_q;
    assign db_estado = state_q;

endmodule

// File: tb/tb_jogador_automatico.sv
// Self-checking bench for jogador_automatico: the bench plays the game side, showing
// random sequences on leds and checking the replayed presses against its own model.
module tb_jogador_automatico;

    localparam int MAX_J   = 16;
    localparam int JOGAR_C = 5;
    localparam int PRESS_C = 10;
    localparam int GAP_C   = 10;
    localparam int ERR_R   = 5;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       iniciar = 1'b0;
    logic [3:0] leds = 4'd0;
    logic       pronto = 1'b0;
    logic       ganhou = 1'b0;
    logic       perdeu = 1'b0;
    logic       timeout = 1'b0;
    logic       jogar;
    logic [3:0] botoes;
    logic       ocupado;
    logic [1:0] resultado;
    logic [4:0] db_rodada;
    logic [3:0] db_estado;

    int n_vec = 0;
    int n_err = 0;
    logic [3:0] seq [MAX_J];

    jogador_automatico #(
        .MAX_JOGADAS  (MAX_J),
        .JOGAR_CYCLES (JOGAR_C),
        .PRESS_CYCLES (PRESS_C),
        .GAP_CYCLES   (GAP_C),
        .ERR_ROUND    (ERR_R)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .iniciar   (iniciar),
        .leds      (leds),
        .pronto    (pronto),
        .ganhou    (ganhou),
        .perdeu    (perdeu),
        .timeout   (timeout),
        .jogar     (jogar),
        .botoes    (botoes),
        .ocupado   (ocupado),
        .resultado (resultado),
        .db_rodada (db_rodada),
        .db_estado (db_estado)
    );

    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: got no end of test, required finish within time limit");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic new_seq();
        for (int i = 0; i < MAX_J; i++) seq[i] = 4'($urandom_range(1, 15));
    endtask

    // Expected value of press i in round r (1-based round).
    function automatic logic [3:0] exp_press(input int r, input int i);
        int v;
        v = int'(seq[i]);
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
        if (r == ERR_R && i == r - 1) v = ((v * 2) + (v / 8)) % 16;
`else
        if (r < 0) v = 0;
`endif
        return 4'(v);
    endfunction

    function automatic logic [3:0] other_nonzero(input logic [3:0] v);
        logic [3:0] w;
        do w = 4'($urandom_range(1, 15)); while (w == v);
        return w;
    endfunction

    task automatic show_item(input logic [3:0] v, input bit glitch, input bit last);
        leds = v;
        repeat ($urandom_range(1, 4)) tick();
        if (glitch) begin
            leds = other_nonzero(v);
            repeat ($urandom_range(1, 3)) tick();
        end
        leds = 4'd0;
        if (!last) repeat ($urandom_range(1, 3)) tick();
    endtask

    task automatic show_round(input int r);
        for (int i = 0; i < r; i++) show_item(seq[i], ($urandom_range(0, 2) == 0), (i == r - 1));
    endtask

    // Called right after the last displayed item dropped to zero.
    task automatic replay_round(input int r);
        int gap;
        int len;
        int rel;
        logic [3:0] v;
        gap = 0;
        do begin
            tick();
            if (botoes == 4'd0) gap++;
        end while (botoes == 4'd0 && gap < 500);
        check_eq("gap_espera", gap, GAP_C);
        for (int i = 0; i < r; i++) begin
            check_eq("press_val", botoes, exp_press(r, i));
            v = botoes;
            len = 1;
            do begin
                tick();
                if (botoes == v) len++;
            end while (botoes == v && len < 500);
            check_eq("press_len", len, PRESS_C);
            check_eq("release_val", botoes, 0);
            if (i < r - 1) begin
                rel = 1;
                do begin
                    tick();
                    if (botoes == 4'd0) rel++;
                end while (botoes == 4'd0 && rel < 500);
                check_eq("release_len", rel, PRESS_C);
            end else begin
                repeat (PRESS_C + 1) tick();
                check_eq("botoes_idle", botoes, 0);
                check_eq("rodada_next", db_rodada, (r < MAX_J) ? r + 1 : r);
                check_eq("ocupado_round", ocupado, 1);
            end
        end
    endtask

    task automatic start_game();
        int n;
        iniciar = 1'b1;
        tick();
        iniciar = 1'b0;
        n = 0;
        while (jogar == 1'b1 && n < 100) begin
            n++;
            tick();
        end
        check_eq("jogar_len", n, JOGAR_C);
        check_eq("ocupado_start", ocupado, 1);
        check_eq("rodada_start", db_rodada, 1);
        check_eq("resultado_clear", resultado, 0);
    endtask

    task automatic wait_press();
        int n;
        n = 0;
        while (botoes == 4'd0 && n < 500) begin
            tick();
            n++;
        end
        check_eq("press_seen", (botoes != 4'd0), 1);
    endtask

    task automatic check_reset_vals(input string tag);
        check_eq({tag, "_jogar"}, jogar, 0);
        check_eq({tag, "_botoes"}, botoes, 0);
        check_eq({tag, "_ocupado"}, ocupado, 0);
        check_eq({tag, "_resultado"}, resultado, 0);
        check_eq({tag, "_rodada"}, db_rodada, 0);
    endtask

    initial begin
        int nz;
        int k;
        repeat (3) tick();
        check_reset_vals("reset");
        reset = 1'b0;
        repeat (3) tick();
        check_eq("idle_no_start", ocupado, 0);

        // Game 1: full game with random sequence; round 2 exercises the LED edge rule.
        new_seq();
        start_game();
        for (int r = 1; r <= MAX_J; r++) begin
            if (r == 2) begin
                leds = seq[0];
                repeat (2) tick();
                leds = other_nonzero(seq[0]);
                repeat (2) tick();
                leds = 4'd0;
                nz = 0;
                repeat (GAP_C + PRESS_C + 5) begin
                    tick();
                    if (botoes != 4'd0) nz++;
                end
                check_eq("glitch_one_event", nz, 0);
                show_item(seq[1], 1'b0, 1'b1);
            end else begin
                show_round(r);
            end
            replay_round(r);
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
            if (r == ERR_R) break;
`endif
        end
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
        perdeu = 1'b1;
        tick();
        perdeu = 1'b0;
        check_eq("res_perdeu", resultado, 2);
`else
        repeat (20) tick();
        check_eq("aguarda_ocupado", ocupado, 1);
        check_eq("aguarda_botoes", botoes, 0);
        ganhou = 1'b1;
        pronto = 1'b1;
        tick();
        ganhou = 1'b0;
        pronto = 1'b0;
        check_eq("res_ganhou", resultado, 1);
`endif
        check_eq("fim_ocupado", ocupado, 0);
        check_eq("fim_botoes", botoes, 0);
        repeat (5) tick();
        check_eq("fim_hold", resultado, 
`ifdef JOGADOR_ERRO_PROPOSITAL_EN
                 2
`else
                 1
`endif
                 );
        check_eq("fim_jogar", jogar, 0);

        // Game 2: timeout during a press.
        new_seq();
        start_game();
        k = $urandom_range(1, 3);
        for (int r = 1; r <= k; r++) begin
            show_round(r);
            replay_round(r);
        end
        show_round(k + 1);
        wait_press();
        repeat ($urandom_range(1, 5)) tick();
        timeout = 1'b1;
        tick();
        timeout = 1'b0;
        check_eq("to_botoes", botoes, 0);
        check_eq("to_resultado", resultado, 3);
        check_eq("to_ocupado", ocupado, 0);

        // Game 3: simultaneous flags follow ganhou > timeout > perdeu.
        start_game();
        ganhou = 1'b1;
        perdeu = 1'b1;
        tick();
        ganhou = 1'b0;
        perdeu = 1'b0;
        check_eq("prio_gp", resultado, 1);
        start_game();
        timeout = 1'b1;
        perdeu = 1'b1;
        tick();
        timeout = 1'b0;
        perdeu = 1'b0;
        check_eq("prio_tp", resultado, 3);

        // Game 4: reset while releasing in round 3.
        new_seq();
        start_game();
        for (int r = 1; r <= 2; r++) begin
            show_round(r);
            replay_round(r);
        end
        show_round(3);
        wait_press();
        nz = 0;
        while (botoes != 4'd0 && nz < 500) begin
            tick();
            nz++;
        end
        repeat (3) tick();
        reset = 1'b1;
        tick();
        check_reset_vals("mid_reset");
        reset = 1'b0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
